// File: rtl/mem_stage_pkg.sv
// Shared constants, state type and fault rule for the memory-access stage.
package mem_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitR
  } mem_state_t;

  // True when a memory op must be rejected: unsupported width code or misaligned address.
  function automatic logic lsu_fault(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic bad_f3;
    logic bad_align;
    if (is_store) begin
      bad_f3 = (f3 > F3_W);
    end else begin
      bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    end
    case (f3[1:0])
      2'b01:   bad_align = addr_lo[0];
      2'b10:   bad_align = (addr_lo != 2'b00);
      default: bad_align = 1'b0;
    endcase
    return bad_f3 | bad_align;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane extraction: picks the addressed byte/half of a read word and extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select lanes, then sign- or zero-extend by width code.
  always_comb begin
    unique case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    value = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    value = {{16{half_lane[15]}}, half_lane};
      F3_BU:   value = {24'h0, byte_lane};
      F3_HU:   value = {16'h0, half_lane};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, byte/half/word loads and stores over a
// req/gnt/rvalid bus, upstream stall while a transfer is in flight.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [6:0]      dp_ctrl,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] mem_forward,
  output logic            misalign,
  output logic            bus_err
);

  mem_state_t state_q, state_d;

  // Operands latched when a legal memory op is accepted
  logic [XLEN-1:0] addr_q, data_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            store_q;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misalign_q, misalign_d;

  logic            is_load, is_store, is_mem, fault, accept_mem;
  logic [31:0]     load_value;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;

  assign is_load    = (dp_ctrl == OP_LOAD);
  assign is_store   = (dp_ctrl == OP_STORE);
  assign is_mem     = is_load | is_store;
  assign fault      = is_mem & lsu_fault(is_store, funct3, mem_addr[1:0]);
  assign accept_mem = (state_q == StIdle) & in_valid & is_mem & ~fault;
  assign stall      = (state_q != StIdle) | accept_mem;

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .value   (load_value)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] wd_cnt_q;
  logic            wd_hit;
  logic            bus_err_q, bus_err_d;

  // Watchdog: zero while idle, so it starts from zero on every REQ entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign wd_hit  = (state_q != StIdle) && (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Next state and registered write-back response
  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
    bus_err_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (dp_ctrl != OP_BRANCH) && (rd_in != 5'd0);
            wb_rd_d    = rd_in;
            wb_data_d  = wr_data;
          end else if (fault) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_in;
            misalign_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (dmem_gnt) begin
          if (store_q) begin
            state_d    = StIdle;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
          end else begin
            state_d = StWaitR;
          end
        end
      end
      StWaitR: begin
        if (dmem_rvalid) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = load_value;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef LSU_TIMEOUT_EN
    // A completion in the same cycle wins over the watchdog
    if (wd_hit && (state_d != StIdle)) begin
      state_d    = StIdle;
      wb_valid_d = 1'b1;
      wb_we_d    = 1'b0;
      wb_rd_d    = rd_q;
      bus_err_d  = 1'b1;
    end
`endif
  end

  // State and write-back registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
`ifdef LSU_TIMEOUT_EN
      bus_err_q  <= bus_err_d;
`endif
    end
  end

  // Capture operands on REQ entry; upstream is free to change while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      store_q <= 1'b0;
    end else if (accept_mem) begin
      addr_q  <= mem_addr;
      data_q  <= wr_data;
      f3_q    <= funct3;
      rd_q    <= rd_in;
      store_q <= is_store;
    end
  end

  // Byte enables and lane-replicated store data from the latched operands
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_q[1:0];
        wdata_c = {4{data_q[7:0]}};
      end
      2'b01: begin
        be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{data_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = data_q;
      end
    endcase
  end

  assign dmem_req    = (state_q == StReq);
  assign dmem_we     = dmem_req & store_q;
  assign dmem_be     = dmem_req ? be_c : 4'b0000;
  assign dmem_addr   = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata  = dmem_we ? wdata_c : '0;

  assign wb_valid    = wb_valid_q;
  assign wb_we       = wb_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign mem_forward = wb_data_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expectations, a bus responder and a
// write-back monitor pop and compare.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk, rst_n, in_valid;
  logic [6:0]  dp_ctrl;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic [31:0] mem_addr, wr_data;
  logic        stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_we, misalign, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mem_forward;

  mem_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .dp_ctrl     (dp_ctrl),
    .funct3      (funct3),
    .rd_in       (rd_in),
    .mem_addr    (mem_addr),
    .wr_data     (wr_data),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mem_forward (mem_forward),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    bit          we;
    logic [4:0]  rd;
    bit          chk_rd;
    bit          mis;
    bit          berr;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
  } req_exp_t;

  wb_exp_t  wbq[$];
  req_exp_t rq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int gcnt     = 0;
  bit hold_r   = 0;
  bit pending_r = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Write-back monitor
  always @(negedge clk) begin : mon
    wb_exp_t e;
    if (rst_n) begin
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          fail_now("unexpected_wb");
        end else begin
          e = wbq.pop_front();
          check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
          check("misalign", {31'd0, misalign}, {31'd0, e.mis});
          check("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
          if (e.chk_data) begin
            check("wb_data", wb_data, e.data);
            check("mem_forward", mem_forward, e.data);
          end
          if (e.chk_rd) check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          done_cnt++;
        end
      end else if (misalign || bus_err) begin
        fail_now("fault_pulse_without_wb");
      end
    end
  end

  // Data-memory responder
  initial begin : resp
    req_exp_t r;
    int rcnt;
    logic [31:0] rword;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'd0;
    rcnt = 0;
    rword = 32'd0;
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata = $urandom;
      if (!rst_n) begin
        gcnt = 0;
      end else if (dmem_req) begin
        if (rq.size() == 0) begin
          fail_now("unexpected_req");
        end else begin
          check("dmem_addr", dmem_addr, rq[0].addr);
          if (gcnt >= rq[0].gdly) begin
            r = rq.pop_front();
            gcnt = 0;
            dmem_gnt = 1'b1;
            check("dmem_we", {31'd0, dmem_we}, {31'd0, r.we});
            if (r.we) begin
              check("dmem_be", {28'd0, dmem_be}, {28'd0, r.be});
              check("dmem_wdata", dmem_wdata, r.wdata);
            end else begin
              pending_r = 1;
              rword = r.rdata;
              rcnt = r.rdly;
            end
            // rvalid alongside gnt must not be taken as the load data
            if ($urandom_range(0, 1) == 1) dmem_rvalid = 1'b1;
          end else begin
            gcnt++;
          end
        end
      end else if (pending_r && !hold_r) begin
        if (rcnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = rword;
          pending_r = 0;
        end else begin
          rcnt--;
        end
      end
    end
  end

  // Reference model from the stage's rules, then drive one op and wait for its write-back
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rword, input int gd, input int rdl);
    bit ld, st, flt, legal;
    int o, nb, prev;
    logic [31:0] sh;
    wb_exp_t e;
    req_exp_t r;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    o  = int'(addr[1:0]);
    nb = 1 << f3[1:0];
    flt = 0;
    if (ld) flt = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (st) flt = (f3 > 3'd2);
    if ((ld || st) && (o % nb != 0)) flt = 1;
    legal = (ld || st) && !flt;
    e = '{data: 32'd0, chk_data: 0, we: 0, rd: rd, chk_rd: 1, mis: 0, berr: 0};
    r = '{addr: addr & 32'hFFFF_FFFC, we: st, be: 4'd0, wdata: 32'd0, rdata: rword,
          gdly: gd, rdly: rdl};
    if (!ld && !st) begin
      e.we = (op != OP_BRANCH) && (rd != 5'd0);
      e.data = data;
      e.chk_data = 1;
    end else if (flt) begin
      e.mis = 1;
      e.chk_rd = 0;
    end else if (st) begin
      e.chk_rd = 0;
      r.be = 4'(((1 << nb) - 1) << o);
      if (nb == 1) r.wdata = {24'd0, data[7:0]} * 32'h0101_0101;
      else if (nb == 2) r.wdata = {16'd0, data[15:0]} * 32'h0001_0001;
      else r.wdata = data;
      rq.push_back(r);
    end else begin
      sh = rword >> (8 * o);
      if (nb == 1) e.data = f3[2] ? (sh & 32'hFF) : 32'($signed(sh[7:0]));
      else if (nb == 2) e.data = f3[2] ? (sh & 32'hFFFF) : 32'($signed(sh[15:0]));
      else e.data = rword;
      e.we = (rd != 5'd0);
      e.chk_data = 1;
      rq.push_back(r);
    end
    wbq.push_back(e);

    @(negedge clk);
    dp_ctrl = op;
    funct3 = f3;
    rd_in = rd;
    mem_addr = addr;
    wr_data = data;
    in_valid = 1'b1;
    #1;
    check("stall_issue", {31'd0, stall}, {31'd0, legal});
    prev = done_cnt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dp_ctrl = 7'($urandom);
    funct3 = 3'($urandom);
    rd_in = 5'($urandom);
    mem_addr = $urandom;
    wr_data = $urandom;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != prev) break;
      if (legal) check("stall_busy", {31'd0, stall}, 32'd1);
      else check("stall_nonmem", {31'd0, stall}, 32'd0);
    end
    if (done_cnt == prev) fail_now("wb_timeout");
    else check("stall_done", {31'd0, stall}, 32'd0);
  endtask

  initial begin : main
    logic [6:0] alu_ops [5];
    logic [31:0] ra;
    logic [2:0] f3;
    int k;
    alu_ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111, OP_BRANCH};
    rst_n = 1'b0;
    in_valid = 1'b0;
    dp_ctrl = 7'd0;
    funct3 = 3'd0;
    rd_in = 5'd0;
    mem_addr = 32'd0;
    wr_data = 32'd0;
    #23;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fwd", mem_forward, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(7'b0110011, 3'd0, 5'd5, 32'h0, 32'h0000_1234, 32'h0, 0, 0);
    issue(OP_LOAD, F3_B, 5'd9, 32'h103, 32'h0, 32'h80FF_FF7F, 2, 1);
    issue(OP_LOAD, F3_HU, 5'd10, 32'h22, 32'h0, 32'hBEEF_0000, 0, 0);
    issue(OP_LOAD, F3_H, 5'd11, 32'h22, 32'h0, 32'hBEEF_0000, 1, 2);
    issue(OP_STORE, F3_B, 5'd1, 32'h41, 32'h1234_56AB, 32'h0, 1, 0);
    issue(OP_LOAD, F3_W, 5'd12, 32'h6, 32'h0, 32'h0, 0, 0);
    issue(OP_STORE, F3_H, 5'd0, 32'h3, 32'hDEAD_BEEF, 32'h0, 0, 0);
    issue(OP_BRANCH, 3'd1, 5'd4, 32'h0, 32'hCAFE_0001, 32'h0, 0, 0);
    issue(7'b0010011, 3'd0, 5'd0, 32'h0, 32'h7777_0000, 32'h0, 0, 0);
    issue(OP_STORE, F3_W, 5'd2, 32'h80, 32'hA5A5_5A5A, 32'h0, 3, 0);
    issue(OP_LOAD, 3'b110, 5'd3, 32'h0, 32'h0, 32'h0, 0, 0);
    issue(OP_STORE, 3'b100, 5'd3, 32'h0, 32'h0, 32'h0, 0, 0);

    // Reset in WAIT_R: no write-back may appear for the aborted load
    hold_r = 1;
    rq.push_back('{addr: 32'h200, we: 0, be: 4'd0, wdata: 32'd0, rdata: 32'h0, gdly: 0,
                   rdly: 0});
    @(negedge clk);
    dp_ctrl = OP_LOAD;
    funct3 = F3_W;
    rd_in = 5'd3;
    mem_addr = 32'h200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 50 && !pending_r; i++) @(negedge clk);
    if (!pending_r) fail_now("abort_no_gnt");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_req", {31'd0, dmem_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_wb", {31'd0, wb_valid}, 32'd0);
    pending_r = 0;
    hold_r = 0;
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_LOAD, F3_W, 5'd7, 32'h204, 32'h0, 32'h1357_9BDF, 1, 1);

`ifdef LSU_TIMEOUT_EN
    begin : timeout_case
      int reqs;
      int prev;
      reqs = 0;
      prev = done_cnt;
      wbq.push_back('{data: 32'd0, chk_data: 0, we: 0, rd: 5'd0, chk_rd: 0, mis: 0, berr: 1});
      rq.push_back('{addr: 32'h300, we: 0, be: 4'd0, wdata: 32'd0, rdata: 32'h0,
                     gdly: 1000000, rdly: 0});
      @(negedge clk);
      dp_ctrl = OP_LOAD;
      funct3 = F3_W;
      rd_in = 5'd8;
      mem_addr = 32'h300;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        #1;
        if (!dmem_req) break;
        reqs++;
      end
      check("timeout_req_cycles", reqs, 32'd255);
      for (int i = 0; i < 5 && done_cnt == prev; i++) @(negedge clk);
      if (done_cnt == prev) fail_now("timeout_no_wb");
      rq.delete();
      gcnt = 0;
    end
`endif

    // Randomized mix
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      ra = $urandom;
      if (k < 3) begin
        issue(alu_ops[$urandom_range(0, 4)], 3'($urandom), 5'($urandom), ra, $urandom,
              32'h0, 0, 0);
      end else if (k < 7) begin
        if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
        else begin
          case ($urandom_range(0, 4))
            0: f3 = F3_B;
            1: f3 = F3_H;
            2: f3 = F3_W;
            3: f3 = F3_BU;
            default: f3 = F3_HU;
          endcase
        end
        issue(OP_LOAD, f3, 5'($urandom), ra, $urandom, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3));
      end else begin
        f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
        issue(OP_STORE, f3, 5'($urandom), ra, $urandom, 32'h0, $urandom_range(0, 3), 0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    if (wbq.size() != 0) fail_now("wb_queue_not_empty");
    if (rq.size() != 0) fail_now("req_queue_not_empty");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench watchdog expired");
  end

endmodule
